// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types and default sizes for the Montgomery modular-exponentiation controller.
package mont_exp_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 1024;
    localparam int unsigned DEF_EXP_W = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE_XT,
        S_WAIT_XT,
        S_ISSUE_SQR,
        S_WAIT_SQR,
        S_ISSUE_MUL,
        S_WAIT_MUL,
        S_ISSUE_FIN,
        S_WAIT_FIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Computes result = x^e mod N using Xt = x*R mod N, A starting at R mod N.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned EXP_W = DEF_EXP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r_n,
    input  logic [WIDTH-1:0] r2_n,
    input  logic [EXP_W-1:0] e,
    input  logic [5:0]       e_len,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH:0]   mm_result,
    input  logic             mm_done,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IW = $clog2(EXP_W + 1);
    localparam int unsigned BW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, n_q, n_d, r2_q, r2_d;
    logic [WIDTH-1:0] a_q, a_d, xt_q, xt_d, res_q, res_d;
    logic [WIDTH-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [IW-1:0]    i_q, i_d;
    logic             mm_start_q, mm_start_d, busy_q, busy_d, done_q, done_d;

    logic [IW-1:0]    i_dec;
    logic [IW-1:0]    i_init;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] res_lo;
    logic             unused_msb;

    assign i_dec      = i_q - IW'(1);
    assign i_init     = (32'(e_len) > 32'(EXP_W)) ? IW'(EXP_W) : IW'(e_len);
    assign bit_idx    = BW'(i_dec);
    assign res_lo     = mm_result[WIDTH-1:0];
    assign unused_msb = mm_result[WIDTH];

    // Next-state, register capture and operand selection
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        n_d        = n_q;
        r2_d       = r2_q;
        e_d        = e_q;
        i_d        = i_q;
        a_d        = a_q;
        xt_d       = xt_q;
        res_d      = res_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    n_d     = n;
                    r2_d    = r2_n;
                    e_d     = e;
                    a_d     = r_n;
                    i_d     = i_init;
                    state_d = S_ISSUE_XT;
                end
            end
            S_ISSUE_XT:  state_d = S_WAIT_XT;
            S_ISSUE_SQR: state_d = S_WAIT_SQR;
            S_ISSUE_MUL: state_d = S_WAIT_MUL;
            S_ISSUE_FIN: state_d = S_WAIT_FIN;
            S_WAIT_XT: begin
                if (mm_done) begin
                    xt_d    = res_lo;
                    state_d = (i_q != '0) ? S_ISSUE_SQR : S_ISSUE_FIN;
                end
            end
            S_WAIT_SQR: begin
                if (mm_done) begin
                    a_d = res_lo;
                    if (e_q[bit_idx]) begin
                        state_d = S_ISSUE_MUL;
                    end else begin
                        i_d     = i_dec;
                        state_d = (i_dec != '0) ? S_ISSUE_SQR : S_ISSUE_FIN;
                    end
                end
            end
            S_WAIT_MUL: begin
                if (mm_done) begin
                    a_d     = res_lo;
                    i_d     = i_dec;
                    state_d = (i_dec != '0) ? S_ISSUE_SQR : S_ISSUE_FIN;
                end
            end
            S_WAIT_FIN: begin
                if (mm_done) begin
                    res_d   = res_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Operands are loaded on entry to an ISSUE state and held through its WAIT state
        unique case (state_d)
            S_ISSUE_XT: begin
                mm_a_d = x_d;
                mm_b_d = r2_d;
            end
            S_ISSUE_SQR: begin
                mm_a_d = a_d;
                mm_b_d = a_d;
            end
            S_ISSUE_MUL: begin
                mm_a_d = a_d;
                mm_b_d = xt_d;
            end
            S_ISSUE_FIN: begin
                mm_a_d = a_d;
                mm_b_d = WIDTH'(1);
            end
            default: ;
        endcase

        mm_start_d = (state_d == S_ISSUE_XT)  || (state_d == S_ISSUE_SQR) ||
                     (state_d == S_ISSUE_MUL) || (state_d == S_ISSUE_FIN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            n_q        <= '0;
            r2_q       <= '0;
            e_q        <= '0;
            i_q        <= '0;
            a_q        <= '0;
            xt_q       <= '0;
            res_q      <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            n_q        <= n_d;
            r2_q       <= r2_d;
            e_q        <= e_d;
            i_q        <= i_d;
            a_q        <= a_d;
            xt_q       <= xt_d;
            res_q      <= res_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = n_q;
    assign result   = res_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Randomised bench for mont_exp_ctrl with a 5-cycle behavioural Montgomery core (R = 256).
module tb_mont_exp_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned EW = 8;

    logic          clk, reset, start;
    logic [W-1:0]  x, n, r_n, r2_n;
    logic [EW-1:0] e;
    logic [5:0]    e_len;
    logic          mm_start, mm_done, done, busy;
    logic [W-1:0]  mm_a, mm_b, mm_m, result;
    logic [W:0]    mm_result;

    mont_exp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .n(n), .r_n(r_n), .r2_n(r2_n),
        .e(e), .e_len(e_len), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int cur_n     = 221;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int powmod(input int b, input int ex, input int m);
        longint r = 1 % m;
        longint bb = b % m;
        for (int k = 0; k < 32; k++) begin
            if (ex[k]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return int'(r);
    endfunction

    function automatic int montmul(input int a, input int b, input int m);
        int rinv = 0;
        for (int k = 1; k < m; k++) if ((256 * k) % m == 1) rinv = k;
        return int'((longint'(a) * b % m) * rinv % m);
    endfunction

    // Behavioural core: result appears as a one-cycle mm_done pulse 5 cycles after mm_start
    logic         core_done, spur_done;
    int           cnt, ca, cb, cm;
    assign mm_done = core_done | spur_done;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            cnt <= 0;
        end else if (mm_start) begin
            cnt <= 5;
            ca  <= int'(mm_a);
            cb  <= int'(mm_b);
            cm  <= int'(mm_m);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                check("hold_a", mm_a, ca);
                check("hold_b", mm_b, cb);
                check("mm_m", mm_m, cur_n);
                core_done <= 1'b1;
                mm_result <= {1'($urandom_range(1, 0)), 8'(montmul(ca, cb, cm))};
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (mm_start) start_cnt <= start_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic apply(input int xv, input int nv, input int ev, input int elen);
        x     = 8'(xv);
        n     = 8'(nv);
        r_n   = 8'(256 % nv);
        r2_n  = 8'(65536 % nv);
        e     = 8'(ev);
        e_len = 6'(elen);
        cur_n = nv;
    endtask

    // mode 0: plain; 1: start re-pulsed and x changed while busy; 2: spurious mm_done at 2nd issue
    task automatic run_exp(input int xv, input int nv, input int ev, input int elen, input int mode,
                           output int res, output int ops, output int dn);
        int s0, d0;
        bit seen;
        @(negedge clk);
        apply(xv, nv, ev, elen);
        s0 = start_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            if (mode == 1 && k == 10) begin start = 1'b1; x = 8'(xv + 3); end
            if (mode == 1 && k == 14) begin start = 1'b0; end
            if (mode == 2 && mm_start && (start_cnt - s0) == 1) spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) check("timeout", 1, 0);
        res = int'(result);
        repeat (8) @(negedge clk);
        x   = 8'(xv);
        ops = start_cnt - s0;
        dn  = done_cnt - d0;
    endtask

    initial begin
        int res, ops, dn, s0, d0, i0, eff, prev;
        bit got;
        clk = 1'b0; reset = 1'b1; start = 1'b0; spur_done = 1'b0;
        apply(5, 221, 11, 4);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_result", result, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_mm_m", mm_m, 0);
        reset = 1'b0;

        run_exp(5, 221, 11, 4, 0, res, ops, dn);
        check("s1_result", res, 164);
        check("s1_ops", ops, 9);
        check("s1_done", dn, 1);

        run_exp(5, 221, 11, 0, 0, res, ops, dn);
        check("s2_result", res, 1);
        check("s2_ops", ops, 2);

        run_exp(5, 221, 0, 4, 0, res, ops, dn);
        check("s3_result", res, 1);
        check("s3_ops", ops, 6);

        run_exp(5, 221, 11, 4, 1, res, ops, dn);
        check("s4_result", res, 164);
        check("s4_done", dn, 1);
        check("s4_ops", ops, 9);

        // Reset while the first square is outstanding
        @(negedge clk);
        apply(5, 221, 11, 4);
        s0 = start_cnt; d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (mm_start && (start_cnt - s0) == 1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) check("s5_timeout", 1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s5_busy", busy, 0);
        check("s5_mm_start", mm_start, 0);
        check("s5_result", result, 0);
        repeat (10) @(negedge clk);
        check("s5_no_done", done_cnt - d0, 0);
        run_exp(5, 221, 11, 4, 0, res, ops, dn);
        check("s5_restart", res, 164);

        // Spurious completion pulses
        prev = int'(result);
        d0 = done_cnt;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("s6_idle_busy", busy, 0);
        check("s6_idle_result", result, prev);
        repeat (3) @(negedge clk);
        check("s6_idle_done", done_cnt - d0, 0);
        run_exp(5, 221, 11, 4, 2, res, ops, dn);
        check("s6_sqr_result", res, 164);
        check("s6_sqr_ops", ops, 9);

        // Exponent length beyond EXP_W is clamped
        run_exp(7, 221, 8'hA5, 40, 0, res, ops, dn);
        check("clamp_result", res, powmod(7, 8'hA5, 221));
        check("clamp_ops", ops, 2 + 8 + $countones(8'hA5));

        for (int t = 0; t < 24; t++) begin
            int nv, xv, ev, elen;
            nv   = 2 * $urandom_range(127, 1) + 1;
            xv   = $urandom_range(nv - 1, 0);
            ev   = $urandom_range(255, 0);
            elen = $urandom_range(12, 0);
            i0   = (elen > 8) ? 8 : elen;
            eff  = ev & ((1 << i0) - 1);
            run_exp(xv, nv, ev, elen, 0, res, ops, dn);
            check($sformatf("rnd%0d_result", t), res, powmod(xv, eff, nv));
            check($sformatf("rnd%0d_ops", t), ops, 2 + i0 + $countones(eff));
            check($sformatf("rnd%0d_done", t), dn, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
